// File: rtl/dc_servo_pkg.sv
// Shared state encodings, default parameters and the correction clamp helper
// for the DC-offset servo.
package dc_servo_pkg;

  localparam int DEF_LOG2_N      = 16;
  localparam int DEF_DEADBAND    = 0;
  localparam int DEF_DC_LIMIT    = 32;
  localparam int DEF_LOCK_BLOCKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // Saturate a widened correction to +/-lim and return it as 8-bit signed.
  function automatic logic signed [7:0] clamp_dc(input logic signed [9:0] v,
                                                 input logic signed [9:0] lim);
    logic signed [9:0] r;
    r = v;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    return r[7:0];
  endfunction

endpackage

// File: rtl/dc_servo_block_accumulator.sv
// Block sum of corrected samples with a sample counter; 'last' flags the
// final sample of an N = 2^LOG2_N block.
module block_accumulator #(
  parameter int LOG2_N = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [7:0]        c,
  output logic signed [7+LOG2_N:0] acc,
  output logic                     last
);

  logic signed [7+LOG2_N:0] r_acc;
  logic [LOG2_N-1:0]        r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (enable) begin
      r_acc <= r_acc + {{LOG2_N{c[7]}}, c};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign acc  = r_acc;
  assign last = &r_cnt;

endmodule

// File: rtl/dc_servo.sv
// Closed-loop DC-offset canceller for one 8-bit rail: averages N corrected
// samples per block and nudges the correction one LSB against the mean.
module dc_servo
  import dc_servo_pkg::*;
#(
  parameter int LOG2_N      = DEF_LOG2_N,
  parameter int DEADBAND    = DEF_DEADBAND,
  parameter int DC_LIMIT    = DEF_DC_LIMIT,
  parameter int LOCK_BLOCKS = DEF_LOCK_BLOCKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] x,
  input  logic              en,
  input  logic signed [7:0] manual_dc,
  output logic signed [7:0] dc,
  output logic signed [7:0] mean,
  output logic              update,
  output logic              locked
);

  localparam int LW = $clog2(LOCK_BLOCKS + 2);
  localparam logic signed [9:0] DB  = 10'(DEADBAND);
  localparam logic signed [9:0] LIM = 10'(DC_LIMIT);
  localparam logic [LW-1:0]     LB  = LW'(LOCK_BLOCKS);

  state_e r_state, w_state_nxt;

  logic signed [7:0]        r_dc, r_mean;
  logic                     r_update, r_locked;
  logic [LW-1:0]            r_lock_cnt, w_lock_nxt;

  logic signed [7:0]        w_c, w_m, w_dc_nxt;
  logic signed [7+LOG2_N:0] w_acc, w_shift;
  logic signed [9:0]        w_m10, w_dc10, w_step;
  logic                     w_last, w_in_db;

  // Same wrapping 8-bit add the quantizer adder performs.
  assign w_c = x + r_dc;

  block_accumulator #(.LOG2_N(LOG2_N)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state != ST_ACCUM),
    .enable (r_state == ST_ACCUM),
    .c      (w_c),
    .acc    (w_acc),
    .last   (w_last)
  );

  assign w_shift = w_acc >>> LOG2_N;
  assign w_m     = w_shift[7:0];
  assign w_m10   = {{2{w_m[7]}}, w_m};
  assign w_dc10  = {{2{r_dc[7]}}, r_dc};
  assign w_in_db = (w_m10 <= DB) && (w_m10 >= -DB);

  always_comb begin
    w_step = w_dc10;
    if (w_m10 > DB)       w_step = w_dc10 - 10'sd1;
    else if (w_m10 < -DB) w_step = w_dc10 + 10'sd1;
  end

  // Clamp after stepping so an out-of-range manual seed is pulled in at the
  // first block end.
  assign w_dc_nxt = clamp_dc(w_step, LIM);

  always_comb begin
    w_lock_nxt = '0;
    if (w_in_db) w_lock_nxt = (r_lock_cnt >= LB) ? LB : r_lock_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (en) w_state_nxt = ST_ACCUM;
      ST_ACCUM:  if (!en) w_state_nxt = ST_IDLE;
                 else if (w_last) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = en ? ST_ACCUM : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dc       <= '0;
      r_mean     <= '0;
      r_update   <= 1'b0;
      r_locked   <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dc       <= manual_dc;
          r_locked   <= 1'b0;
          r_lock_cnt <= '0;
        end
        ST_ACCUM: begin
          if (!en) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
          end
        end
        ST_UPDATE: begin
          r_mean     <= w_m;
          r_dc       <= w_dc_nxt;
          r_update   <= 1'b1;
          r_lock_cnt <= w_lock_nxt;
          r_locked   <= (w_lock_nxt >= LB);
        end
        default: ;
      endcase
    end
  end

  assign dc     = r_dc;
  assign mean   = r_mean;
  assign update = r_update;
  assign locked = r_locked;

endmodule

// File: tb/tb_dc_servo.sv
// Self-checking bench for dc_servo with N = 16: expected block results are
// queued as stimulus is applied and compared on each update pulse.
module tb_dc_servo;
  import dc_servo_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] x;
  logic              en;
  logic signed [7:0] manual_dc;
  logic signed [7:0] dc;
  logic signed [7:0] mean;
  logic              update;
  logic              locked;

  dc_servo #(
    .LOG2_N      (4),
    .DEADBAND    (DEF_DEADBAND),
    .DC_LIMIT    (DEF_DC_LIMIT),
    .LOCK_BLOCKS (DEF_LOCK_BLOCKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .en        (en),
    .manual_dc (manual_dc),
    .dc        (dc),
    .mean      (mean),
    .update    (update),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int mean;
    int dc;
    int lk;
  } exp_t;

  typedef struct {
    logic [7:0] x;
    int         mean;
    int         dc;
    int         lk;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the next update pulse (bounded) and check it against the
  // oldest queued expectation.
  task automatic check_pulse(input string nm);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (update !== 1'b1 && n < 60);
    if (sb.size() == 0) begin
      chk({nm, "_queue"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_gap"},    (update === 1'b1) ? n : -1, e.gap);
    chk({nm, "_mean"},   int'(mean), e.mean);
    chk({nm, "_dc"},     int'(dc),   e.dc);
    chk({nm, "_locked"}, int'(locked), e.lk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  vec_t tbl[10];
  int   pulses;

  initial begin
    tbl[0] = '{8'h05, 5, -1, 0};
    tbl[1] = '{8'h05, 4, -2, 0};
    tbl[2] = '{8'h05, 3, -3, 0};
    tbl[3] = '{8'h05, 2, -4, 0};
    tbl[4] = '{8'h05, 1, -5, 0};
    tbl[5] = '{8'h05, 0, -5, 0};
    tbl[6] = '{8'h05, 0, -5, 0};
    tbl[7] = '{8'h05, 0, -5, 0};
    tbl[8] = '{8'h05, 0, -5, 1};
    tbl[9] = '{8'h05, 0, -5, 1};

    // Reset state, with a nonzero manual seed that reset must override.
    reset = 1'b1; en = 1'b0; x = 8'sh05; manual_dc = 8'sh11;
    step(3);
    chk("rst_dc", int'(dc), 0);
    chk("rst_mean", int'(mean), 0);
    chk("rst_update", int'(update), 0);
    chk("rst_locked", int'(locked), 0);
    manual_dc = 8'sh00;
    reset = 1'b0;
    step(2);

    // Constant +5 offset converging to dc=-5 and locking.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = tbl[i].x;
      sb.push_back('{(i == 0) ? 18 : 17, tbl[i].mean, tbl[i].dc, tbl[i].lk});
      check_pulse($sformatf("conv%0d", i));
    end

    // Dropping en drops locked on the next cycle.
    en = 1'b0; manual_dc = 8'sh00;
    step(1);
    chk("unlock_dly", int'(locked), 0);
    step(1);
    chk("idle_dc", int'(dc), 0);

    // Full-scale negative input: dc walks up to +DC_LIMIT and holds.
    x = 8'sh80;
    en = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      sb.push_back('{(k == 1) ? 18 : 17, -128 + ((k - 1 > 32) ? 32 : k - 1),
                     (k > 32) ? 32 : k, 0});
      check_pulse($sformatf("sat%0d", k));
    end

    // Manual seed F0 then servo with x=-16.
    en = 1'b0; manual_dc = 8'shF0;
    step(2);
    chk("seed_dc", int'(dc), -16);
    x = 8'shF0;
    en = 1'b1;
    sb.push_back('{18, -32, -15, 0});
    check_pulse("seedF0_a");
    sb.push_back('{17, -31, -14, 0});
    check_pulse("seedF0_b");

    // Out-of-range seed is clamped at the first block end.
    en = 1'b0; manual_dc = 8'sh64; x = 8'sh00;
    step(2);
    chk("seed100_dc", int'(dc), 100);
    en = 1'b1;
    sb.push_back('{18, 100, 32, 0});
    check_pulse("clamp_a");
    sb.push_back('{17, 32, 31, 0});
    check_pulse("clamp_b");

    // en dropped after 7 samples: partial block discarded.
    en = 1'b0; manual_dc = 8'sh00;
    step(2);
    x = 8'sh03;
    en = 1'b1;
    step(8);
    en = 1'b0; manual_dc = 8'sh07;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (update === 1'b1) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_mean", int'(mean), 32);
    chk("abort_dc", int'(dc), 7);
    chk("abort_locked", int'(locked), 0);

    // Lock, then reset mid-block.
    manual_dc = 8'sh02; x = 8'shFF;
    step(1);
    en = 1'b1;
    sb.push_back('{18, 1, 1, 0});
    check_pulse("rlock0");
    for (int i = 1; i <= 4; i++) begin
      sb.push_back('{17, 0, 1, (i == 4) ? 1 : 0});
      check_pulse($sformatf("rlock%0d", i));
    end
    step(5);
    #2 reset = 1'b1;
    #1;
    chk("async_dc", int'(dc), 0);
    chk("async_mean", int'(mean), 0);
    chk("async_update", int'(update), 0);
    chk("async_locked", int'(locked), 0);
    manual_dc = 8'sh02; x = 8'sh01;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.push_back('{18, 3, 1, 0});
    check_pulse("post_rst");

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
